mem_req_arbiter: RTL
====================

# mem_req_arbiter

Request arbiter directly upstream of the PSRAM memory controller. Accepts byte-wide memory requests from the 6510 CPU port and the VIC-II video port, maps them into the 24-bit PSRAM address space, and issues one transaction at a time on the controller's chip-select/busy/data-ready interface. Returns read data and acknowledges to the winning requester, and supervises each transaction with a watchdog.

## Interface
Parameters:
- CPU_BASE, 8'h00: PSRAM address bits [23:16] for CPU accesses.
- VIC_BASE, 8'h00: PSRAM address bits [23:16] for VIC accesses.
- TIMEOUT_CYCLES, 1023: watchdog limit in i_clkRAM cycles per transaction; counter width is $clog2(TIMEOUT_CYCLES+1).
- WBUF_DEPTH, 4: write-post buffer entries, power of two (used only with WRITE_POST_EN).

Ports:
- i_clkRAM  in  1  single clock, shared with the memory controller.
- reset  in  1  synchronous, active-high; sampled on the rising edge of i_clkRAM.
- i_cpu_req  in  1  CPU request; held high until o_cpu_ack.
- i_cpu_we  in  1  1 = write, 0 = read; stable while i_cpu_req is high.
- i_cpu_addr  in  16  CPU byte address.
- i_cpu_wdata  in  8  CPU write data.
- o_cpu_ack  out  1  one-cycle completion/accept pulse.
- o_cpu_rdata  out  8  read data; valid in the o_cpu_ack cycle, held afterwards.
- i_vic_req  in  1  VIC read request; held until o_vic_ack.
- i_vic_bank  in  2  VIC bank select.
- i_vic_addr  in  14  VIC address within the bank.
- o_vic_ack  out  1  one-cycle pulse.
- o_vic_rdata  out  8  read data; valid in the o_vic_ack cycle, held afterwards.
- o_cs  out  1  controller chip select, active-low, one-cycle pulse starts a transaction.
- o_write  out  1  1 = write transaction.
- o_address  out  24  transaction address.
- o_dataToWrite  out  8  write data.
- i_dataRead  in  8  controller read data.
- i_busy  in  1  controller busy.
- i_dataReady  in  1  controller read-data-valid pulse.
- o_error  out  1  sticky watchdog timeout flag; cleared only by reset.

## Operation
- Address map: CPU = {CPU_BASE, i_cpu_addr}; VIC = {VIC_BASE, i_vic_bank, i_vic_addr}.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: arbitrate when i_busy = 0. Priority: VIC read > oldest buffered write > CPU direct request. The winner's address, data and direction are latched into o_address, o_write and o_dataToWrite. Transition to ISSUE.
- ISSUE: o_cs = 0 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for i_busy = 1, then go to WAIT_DONE.
- WAIT_DONE:
  - Write: complete on the first cycle with i_busy = 0.
  - Read: complete on i_dataReady = 1. Capture i_dataRead into the requester's rdata register and pulse its ack.
  - After completion, go to IDLE.
- Watchdog: counts from ISSUE onward.
  - On reaching TIMEOUT_CYCLES in WAIT_BUSY or WAIT_DONE: set o_error and return to IDLE.
  - A read requester receives an ack with rdata = 8'hFF.
  - A buffered write is dropped.
- o_address, o_write and o_dataToWrite stay stable from ISSUE until return to IDLE.
- A request is never acked twice. A requester must deassert its req in the cycle after its ack. A req still high two cycles after its ack is treated as a new request.
- Simultaneous VIC and CPU requests: VIC wins; CPU waits.
- Reset mid-transaction: FSM returns to IDLE, buffer empties, no ack is issued. The controller is reset by the same signal.

## Timing
- Reset values: o_cs = 1, o_write = 0, o_address = 0, o_dataToWrite = 0, o_cpu_ack = 0, o_vic_ack = 0, o_cpu_rdata = 0, o_vic_rdata = 0, o_error = 0, FSM = IDLE, watchdog = 0.
- Request sampled high in IDLE at cycle N: o_cs low at N+1; WAIT_BUSY from N+2.
- Read ack: asserted in the cycle after i_dataReady is sampled high.
- Write ack (no posting): asserted in the cycle after i_busy is sampled low in WAIT_DONE.
- After completion, one IDLE cycle before the next o_cs. Minimum spacing between o_cs pulses: 4 cycles plus the controller's busy time.

## Configuration
- WRITE_POST_EN defined:
  - CPU writes enter a WBUF_DEPTH FIFO. o_cpu_ack pulses one cycle after i_cpu_req is sampled if the FIFO is not full; when full, the ack waits until an entry drains.
  - CPU reads are granted only when the FIFO is empty, preserving CPU order.
  - VIC reads bypass the FIFO and may return data older than up to WBUF_DEPTH pending writes.
  - FIFO wrap-around uses log2(WBUF_DEPTH)+1-bit pointers.
- WRITE_POST_EN undefined: no FIFO. CPU writes are acked on completion, exactly like reads, and WBUF_DEPTH is unused.

## Test plan
- Reset held 2 cycles, then released: all outputs at their reset values; o_cs = 1 for 10 idle cycles.
- CPU read of 16'hC000 with CPU_BASE = 8'h01; controller model returns 8'h5A: o_address = 24'h01C000, o_write = 0, single o_cs pulse, o_cpu_rdata = 8'h5A in the o_cpu_ack cycle.
- CPU write of 8'hF0 to 16'hAAAA and VIC read (bank 2'b10, addr 14'h0123) raised in the same cycle: VIC issued first at 24'h008123, then the write at 24'h00AAAA with o_dataToWrite = 8'hF0.
- WRITE_POST_EN, 5 back-to-back CPU writes, WBUF_DEPTH = 4: first 4 acked one cycle after request, 5th acked only after the first write completes; writes issued in order.
- Controller model never asserts i_dataReady on a CPU read: after TIMEOUT_CYCLES, o_error = 1, o_cpu_ack pulses with o_cpu_rdata = 8'hFF, next request is serviced normally.
- Reset asserted during WAIT_DONE: no ack, FSM back to IDLE, o_cs = 1; o_error stays 0 if it was 0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// VIC/CPU request arbiter in front of the PSRAM controller, with a per-transaction watchdog.
// Define WRITE_POST_EN to post CPU writes through a WBUF_DEPTH-entry FIFO.
module mem_req_arbiter #(
    parameter logic [7:0] CPU_BASE       = 8'h00,
    parameter logic [7:0] VIC_BASE       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 1023,
    parameter int         WBUF_DEPTH     = 4
) (
    input  logic        i_clkRAM,
    input  logic        reset,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_rdata,
    input  logic        i_vic_req,
    input  logic [1:0]  i_vic_bank,
    input  logic [13:0] i_vic_addr,
    output logic        o_vic_ack,
    output logic [7:0]  o_vic_rdata,
    output logic        o_cs,
    output logic        o_write,
    output logic [23:0] o_address,
    output logic [7:0]  o_dataToWrite,
    input  logic [7:0]  i_dataRead,
    input  logic        i_busy,
    input  logic        i_dataReady,
    output logic        o_error
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE
    } state_t;
    typedef enum logic [1:0] {OWN_VIC, OWN_CPU, OWN_BUF} owner_t;

    state_t         r_state, w_next;
    owner_t         r_owner, w_sel_owner;
    logic [WDW-1:0] r_wdog;
    logic           r_cpu_ack, r_cpu_ack_d, r_vic_ack, r_vic_ack_d;
    logic [7:0]     r_cpu_rdata, r_vic_rdata;
    logic           r_write, r_error;
    logic [23:0]    r_address;
    logic [7:0]     r_wdata;

    logic           w_cpu_req, w_vic_req, w_cpu_direct, w_buf_valid;
    logic           w_cpu_push, w_grant, w_fin, w_to, w_wd_hit;
    logic [23:0]    w_buf_addr, w_sel_addr;
    logic [7:0]     w_buf_data, w_sel_data;
    logic           w_sel_we;

    // A requester still holds req during its ack cycle and the one after.
    assign w_cpu_req = i_cpu_req && !r_cpu_ack && !r_cpu_ack_d;
    assign w_vic_req = i_vic_req && !r_vic_ack && !r_vic_ack_d;
    assign w_wd_hit  = (r_wdog == WD_LIM);

`ifdef WRITE_POST_EN
    localparam int PW = $clog2(WBUF_DEPTH);
    logic [PW:0]  r_wptr, r_rptr;
    logic [15:0]  r_wb_addr [WBUF_DEPTH];
    logic [7:0]   r_wb_data [WBUF_DEPTH];
    logic         w_empty, w_full, w_pop;

    assign w_empty      = (r_wptr == r_rptr);
    assign w_full       = (r_wptr[PW] != r_rptr[PW]) &&
                          (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_cpu_push   = w_cpu_req && i_cpu_we && !w_full;
    assign w_cpu_direct = w_cpu_req && !i_cpu_we && w_empty;
    assign w_buf_valid  = !w_empty;
    assign w_buf_addr   = {CPU_BASE, r_wb_addr[r_rptr[PW-1:0]]};
    assign w_buf_data   = r_wb_data[r_rptr[PW-1:0]];
    // Entries leave only when their transaction ends, so full means pending.
    assign w_pop        = (w_fin || w_to) && (r_owner == OWN_BUF);

    always_ff @(posedge i_clkRAM) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_cpu_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)      r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clkRAM) begin
        if (w_cpu_push) begin
            r_wb_addr[r_wptr[PW-1:0]] <= i_cpu_addr;
            r_wb_data[r_wptr[PW-1:0]] <= i_cpu_wdata;
        end
    end
`else
    assign w_cpu_push   = 1'b0;
    assign w_cpu_direct = w_cpu_req;
    assign w_buf_valid  = 1'b0;
    assign w_buf_addr   = '0;
    assign w_buf_data   = '0;
    if (WBUF_DEPTH < 1) begin : g_no_wbuf
    end
`endif

    always_comb begin
        w_sel_owner = OWN_CPU;
        w_sel_addr  = {CPU_BASE, i_cpu_addr};
        w_sel_we    = i_cpu_we;
        w_sel_data  = i_cpu_wdata;
        if (w_vic_req) begin
            w_sel_owner = OWN_VIC;
            w_sel_addr  = {VIC_BASE, i_vic_bank, i_vic_addr};
            w_sel_we    = 1'b0;
            w_sel_data  = 8'h00;
        end else if (w_buf_valid) begin
            w_sel_owner = OWN_BUF;
            w_sel_addr  = w_buf_addr;
            w_sel_we    = 1'b1;
            w_sel_data  = w_buf_data;
        end
    end

    always_ff @(posedge i_clkRAM) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_fin   = 1'b0;
        w_to    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!i_busy && (w_vic_req || w_buf_valid || w_cpu_direct)) begin
                    w_grant = 1'b1;
                    w_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (w_wd_hit) begin
                    w_to   = 1'b1;
                    w_next = ST_IDLE;
                end else if (i_busy) begin
                    w_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (r_write ? !i_busy : i_dataReady) begin
                    w_fin  = 1'b1;
                    w_next = ST_IDLE;
                end else if (w_wd_hit) begin
                    w_to   = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clkRAM) begin
        if (reset) begin
            r_owner     <= OWN_VIC;
            r_wdog      <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_ack_d <= 1'b0;
            r_vic_ack   <= 1'b0;
            r_vic_ack_d <= 1'b0;
            r_cpu_rdata <= 8'h00;
            r_vic_rdata <= 8'h00;
            r_write     <= 1'b0;
            r_address   <= 24'h0;
            r_wdata     <= 8'h00;
            r_error     <= 1'b0;
        end else begin
            r_cpu_ack   <= w_cpu_push;
            r_vic_ack   <= 1'b0;
            r_cpu_ack_d <= r_cpu_ack;
            r_vic_ack_d <= r_vic_ack;
            if (r_state == ST_IDLE)  r_wdog <= '0;
            else if (!w_wd_hit)      r_wdog <= r_wdog + 1'b1;
            if (w_grant) begin
                r_owner   <= w_sel_owner;
                r_address <= w_sel_addr;
                r_write   <= w_sel_we;
                r_wdata   <= w_sel_data;
            end
            if (w_to) r_error <= 1'b1;
            // A timed-out read still completes, returning all-ones.
            if (w_fin || w_to) begin
                unique case (r_owner)
                    OWN_VIC: begin
                        r_vic_ack   <= 1'b1;
                        r_vic_rdata <= w_fin ? i_dataRead : 8'hFF;
                    end
                    OWN_CPU: begin
                        r_cpu_ack <= 1'b1;
                        if (!r_write) r_cpu_rdata <= w_fin ? i_dataRead : 8'hFF;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_cs          = (r_state != ST_ISSUE);
    assign o_write       = r_write;
    assign o_address     = r_address;
    assign o_dataToWrite = r_wdata;
    assign o_cpu_ack     = r_cpu_ack;
    assign o_cpu_rdata   = r_cpu_rdata;
    assign o_vic_ack     = r_vic_ack;
    assign o_vic_rdata   = r_vic_rdata;
    assign o_error       = r_error;
endmodule
